// File: rtl/vec_alu_if.sv
// Handshake bundle for vec_alu: input beat channel (in_*) and result channel (out*).
// The slave side is the ALU, the master side is whoever feeds and drains it.
interface vec_alu_if #(
  parameter int NUM_SIZE      = 32,
  parameter int LANES         = 4,
  parameter int CMD_SIZE_LOG2 = 3
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [2**CMD_SIZE_LOG2-1:0]   cmd;
  logic [LANES*NUM_SIZE-1:0]     in1;
  logic [LANES*NUM_SIZE-1:0]     in2;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*NUM_SIZE-1:0]     out;
  logic [LANES-1:0]              out_ovf;
  logic                          out_err;

  modport master (
    output in_valid, in_last, cmd, in1, in2, out_ready,
    input  in_ready, out_valid, out, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_last, cmd, in1, in2, out_ready,
    output in_ready, out_valid, out, out_ovf, out_err
  );
endinterface

// File: rtl/vec_alu.sv
// Lane-parallel signed ALU with a one-beat output register and a SUM accumulator.
// Each accepted beat produces at most one result, one cycle after acceptance.
module vec_alu #(
  parameter int NUM_SIZE      = 32,
  parameter int LANES         = 4,
  parameter int CMD_SIZE_LOG2 = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     enable,
  vec_alu_if.slave bus
);
  localparam int N  = NUM_SIZE;
  localparam int W  = LANES * NUM_SIZE;
  localparam int CW = 2**CMD_SIZE_LOG2;

  localparam logic [CW-1:0] OP_NOOP = CW'(0);
  localparam logic [CW-1:0] OP_ADD  = CW'(1);
  localparam logic [CW-1:0] OP_SUB  = CW'(2);
  localparam logic [CW-1:0] OP_MUL  = CW'(3);
  localparam logic [CW-1:0] OP_MIN  = CW'(4);
  localparam logic [CW-1:0] OP_MAX  = CW'(5);
  localparam logic [CW-1:0] OP_SUM  = CW'(6);

  logic             r_out_valid;
  logic [W-1:0]     r_out;
  logic [LANES-1:0] r_out_ovf;
  logic             r_out_err;
  logic [W-1:0]     r_acc;
  logic [LANES-1:0] r_sticky;

  logic [W-1:0]     w_add, w_sub, w_mul, w_min, w_max, w_accsum;
  logic [LANES-1:0] w_add_ovf, w_sub_ovf, w_mul_ovf, w_accsum_ovf;

  logic [W-1:0]     w_res;
  logic [LANES-1:0] w_ovf;
  logic             w_err;
  logic             w_has_res;
  logic             w_sum_step;
  logic             w_in_ready;
  logic             w_accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [N-1:0]   w_a, w_b, w_acc;
    logic        [N:0]     w_s, w_d, w_as;
    logic signed [2*N-1:0] w_ax, w_bx, w_prod;

    assign w_a   = bus.in1[g*N +: N];
    assign w_b   = bus.in2[g*N +: N];
    assign w_acc = r_acc[g*N +: N];

    // One guard bit is enough to see signed overflow of a two-operand add/sub.
    assign w_s  = {w_a[N-1], w_a} + {w_b[N-1], w_b};
    assign w_d  = {w_a[N-1], w_a} - {w_b[N-1], w_b};
    assign w_as = {w_acc[N-1], w_acc} + {w_a[N-1], w_a};

    assign w_ax   = {{N{w_a[N-1]}}, w_a};
    assign w_bx   = {{N{w_b[N-1]}}, w_b};
    assign w_prod = w_ax * w_bx;

    assign w_add[g*N +: N]    = w_s[N-1:0];
    assign w_sub[g*N +: N]    = w_d[N-1:0];
    assign w_accsum[g*N +: N] = w_as[N-1:0];
    assign w_mul[g*N +: N]    = w_prod[N-1:0];
    assign w_min[g*N +: N]    = (w_a < w_b) ? w_a : w_b;
    assign w_max[g*N +: N]    = (w_a > w_b) ? w_a : w_b;

    assign w_add_ovf[g]    = w_s[N] ^ w_s[N-1];
    assign w_sub_ovf[g]    = w_d[N] ^ w_d[N-1];
    assign w_accsum_ovf[g] = w_as[N] ^ w_as[N-1];
    // Product fits only if the upper half is pure sign extension of the low half.
    assign w_mul_ovf[g]    = (w_prod[2*N-1:N] != {N{w_prod[N-1]}});
  end

  always_comb begin
    w_res      = '0;
    w_ovf      = '0;
    w_err      = 1'b0;
    w_has_res  = 1'b1;
    w_sum_step = 1'b0;
    case (bus.cmd)
      OP_NOOP: w_has_res = 1'b0;
      OP_ADD: begin
        w_res = w_add;
        w_ovf = w_add_ovf;
      end
      OP_SUB: begin
        w_res = w_sub;
        w_ovf = w_sub_ovf;
      end
      OP_MUL: begin
        w_res = w_mul;
        w_ovf = w_mul_ovf;
      end
      OP_MIN: w_res = w_min;
      OP_MAX: w_res = w_max;
      OP_SUM: begin
        if (bus.in_last) begin
          w_res = w_accsum;
          w_ovf = r_sticky | w_accsum_ovf;
        end else begin
          w_has_res  = 1'b0;
          w_sum_step = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // Gating with reset keeps in_ready low while reset is held.
  assign w_in_ready = reset && enable && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_ovf   <= '0;
      r_out_err   <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= '0;
    end else if (!enable) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_ovf   <= '0;
      r_out_err   <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= '0;
    end else if (w_accept) begin
      // Acceptance implies the current result (if any) is leaving this edge.
      r_out_valid <= w_has_res;
      if (w_has_res) begin
        r_out     <= w_res;
        r_out_ovf <= w_ovf;
        r_out_err <= w_err;
      end
      if (w_sum_step) begin
        r_acc    <= w_accsum;
        r_sticky <= r_sticky | w_accsum_ovf;
      end else begin
        r_acc    <= '0;
        r_sticky <= '0;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_vec_alu.sv
// Bench for vec_alu at NUM_SIZE=8, LANES=2: directed vector table, multi-cycle
// sequences, then random traffic against an integer-arithmetic reference model.
module tb_vec_alu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;

  always #5 clk = ~clk;

  vec_alu_if #(.NUM_SIZE(8), .LANES(2), .CMD_SIZE_LOG2(3)) bus ();

  vec_alu #(.NUM_SIZE(8), .LANES(2), .CMD_SIZE_LOG2(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input int l0, input int l1);
    logic [31:0] x, y;
    x = l0;
    y = l1;
    return {y[7:0], x[7:0]};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] o;
    logic [1:0]  v;
    logic        e;
  } res_t;

  res_t exq[$];
  int   macc[2];
  bit   msticky[2];

  function automatic int lane(input logic [15:0] x, input int i);
    logic [7:0] b;
    b = (i == 0) ? x[7:0] : x[15:8];
    return int'($signed(b));
  endfunction

  function automatic bit out_of_range(input int v);
    return (v < -128) || (v > 127);
  endfunction

  function automatic int wrap8(input int v);
    logic [31:0] t;
    logic [7:0]  b;
    t = v;
    b = t[7:0];
    return int'($signed(b));
  endfunction

  task automatic model_beat(input logic [7:0] c, input logic [15:0] a,
                            input logic [15:0] b, input logic last);
    res_t r;
    int   t, x, y;
    logic [31:0] tv;
    r = '0;
    if (c == 8'd6 && !last) begin
      for (int i = 0; i < 2; i++) begin
        t = macc[i] + lane(a, i);
        if (out_of_range(t)) msticky[i] = 1'b1;
        macc[i] = wrap8(t);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        x = lane(a, i);
        y = lane(b, i);
        case (c)
          8'd1: t = x + y;
          8'd2: t = x - y;
          8'd3: t = x * y;
          8'd4: t = (x < y) ? x : y;
          8'd5: t = (x > y) ? x : y;
          8'd6: t = macc[i] + x;
          default: t = 0;
        endcase
        tv = t;
        r.o[i*8 +: 8] = tv[7:0];
        r.v[i] = out_of_range(t) || (c == 8'd6 && msticky[i]);
      end
      if (c > 8'd6) begin
        r = '0;
        r.e = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        macc[i] = 0;
        msticky[i] = 1'b0;
      end
      if (c != 8'd0) exq.push_back(r);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic        ev;
    logic [15:0] eo;
    logic [1:0]  eovf;
    logic        eerr;
  } vec_t;

  vec_t tbl[14];

  task automatic beat(input logic [7:0] c, input logic [15:0] a,
                      input logic [15:0] b, input logic last);
    bus.in_valid = 1'b1;
    bus.cmd      = c;
    bus.in1      = a;
    bus.in2      = b;
    bus.in_last  = last;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.cmd      = 8'd0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_res(input string nm, input logic [15:0] o, input logic [1:0] v, input logic e);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, ".out"}, 32'(bus.out), 32'(o));
    chk({nm, ".ovf"}, 32'(bus.out_ovf), 32'(v));
    chk({nm, ".err"}, 32'(bus.out_err), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{8'd1,   pk(100,-5),  pk(27,3),    1'b0, 1'b1, pk(127,-2),   2'b00, 1'b0};
    tbl[1]  = '{8'd1,   pk(100,0),   pk(28,0),    1'b0, 1'b1, pk(-128,0),   2'b01, 1'b0};
    tbl[2]  = '{8'd1,   pk(-1,-128), pk(-1,-1),   1'b0, 1'b1, pk(-2,127),   2'b10, 1'b0};
    tbl[3]  = '{8'd2,   pk(-128,5),  pk(1,10),    1'b0, 1'b1, pk(127,-5),   2'b01, 1'b0};
    tbl[4]  = '{8'd2,   pk(0,127),   pk(0,-1),    1'b0, 1'b1, pk(0,-128),   2'b10, 1'b0};
    tbl[5]  = '{8'd3,   pk(16,-3),   pk(8,5),     1'b1, 1'b1, pk(-128,-15), 2'b01, 1'b0};
    tbl[6]  = '{8'd3,   pk(-128,-1), pk(-1,-1),   1'b0, 1'b1, pk(-128,1),   2'b01, 1'b0};
    tbl[7]  = '{8'd4,   pk(-128,127),pk(127,-128),1'b0, 1'b1, pk(-128,-128),2'b00, 1'b0};
    tbl[8]  = '{8'd5,   pk(-128,127),pk(127,-128),1'b0, 1'b1, pk(127,127),  2'b00, 1'b0};
    tbl[9]  = '{8'd9,   pk(5,6),     pk(7,8),     1'b0, 1'b1, 16'h0000,     2'b00, 1'b1};
    tbl[10] = '{8'd0,   pk(1,1),     pk(1,1),     1'b1, 1'b0, 16'h0000,     2'b00, 1'b0};
    tbl[11] = '{8'd255, pk(-1,-1),   pk(-1,-1),   1'b1, 1'b1, 16'h0000,     2'b00, 1'b1};
    tbl[12] = '{8'd6,   pk(7,7),     pk(99,99),   1'b1, 1'b1, pk(7,7),      2'b00, 1'b0};
    tbl[13] = '{8'd3,   pk(11,-12),  pk(11,10),   1'b0, 1'b1, pk(121,-120), 2'b00, 1'b0};

    idle_in();
    bus.in1 = '0;
    bus.in2 = '0;
    bus.out_ready = 1'b1;

    // Reset state, with a beat already offered.
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out", 32'(bus.out), 32'd0);
    chk("rst.ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst.err", 32'(bus.out_err), 32'd0);
    idle_in();
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      beat(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].last);
      @(posedge clk); #1;
      idle_in();
      chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d.out", i), 32'(bus.out), 32'(tbl[i].eo));
        chk($sformatf("vec%0d.ovf", i), 32'(bus.out_ovf), 32'(tbl[i].eovf));
        chk($sformatf("vec%0d.err", i), 32'(bus.out_err), 32'(tbl[i].eerr));
      end
    end

    // SUM stream of three beats, then a standalone last beat.
    @(posedge clk); #1; beat(8'd6, pk(1,2), pk(50,50), 1'b0);
    @(posedge clk); #1; beat(8'd6, pk(3,4), pk(50,50), 1'b0);
    chk("sum1.valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1; beat(8'd6, pk(5,6), pk(50,50), 1'b1);
    chk("sum2.valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1; idle_in();
    chk_res("sum3", pk(9,12), 2'b00, 1'b0);
    @(posedge clk); #1;
    chk("sum3.single", 32'(bus.out_valid), 32'd0);
    beat(8'd6, pk(7,7), pk(0,0), 1'b1);
    @(posedge clk); #1; idle_in();
    chk_res("sum_single", pk(7,7), 2'b00, 1'b0);

    // Sticky overflow survives an in-range final sum.
    @(posedge clk); #1; beat(8'd6, pk(100,0), pk(0,0), 1'b0);
    @(posedge clk); #1; beat(8'd6, pk(100,0), pk(0,0), 1'b0);
    @(posedge clk); #1; beat(8'd6, pk(56,3), pk(0,0), 1'b1);
    @(posedge clk); #1; idle_in();
    chk_res("sticky", pk(0,3), 2'b01, 1'b0);

    // A non-SUM beat discards an open accumulation.
    @(posedge clk); #1; beat(8'd6, pk(10,10), pk(0,0), 1'b0);
    @(posedge clk); #1; beat(8'd1, pk(1,1), pk(1,1), 1'b0);
    @(posedge clk); #1; beat(8'd6, pk(1,1), pk(0,0), 1'b1);
    chk_res("discard.add", pk(2,2), 2'b00, 1'b0);
    @(posedge clk); #1; idle_in();
    chk_res("discard.sum", pk(1,1), 2'b00, 1'b0);

    // Backpressure: one result held, following beats wait.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    beat(8'd1, pk(1,1), pk(1,1), 1'b0);
    @(posedge clk); #1;
    beat(8'd1, pk(2,2), pk(2,2), 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk_res($sformatf("bp.hold%0d", k), pk(2,2), 2'b00, 1'b0);
      chk($sformatf("bp.in_ready%0d", k), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    beat(8'd1, pk(3,3), pk(3,3), 1'b0);
    chk_res("bp.res2", pk(4,4), 2'b00, 1'b0);
    @(posedge clk); #1; idle_in();
    chk_res("bp.res3", pk(6,6), 2'b00, 1'b0);
    @(posedge clk); #1;
    chk("bp.drained", 32'(bus.out_valid), 32'd0);

    // enable low flushes the accumulator and a stalled result.
    beat(8'd6, pk(5,5), pk(0,0), 1'b0);
    @(posedge clk); #1; idle_in();
    enable = 1'b0;
    #1;
    chk("en.in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    beat(8'd6, pk(1,1), pk(0,0), 1'b1);
    @(posedge clk); #1; idle_in();
    chk_res("en.acc_cleared", pk(1,1), 2'b00, 1'b0);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    beat(8'd9, pk(3,3), pk(0,0), 1'b0);
    @(posedge clk); #1; idle_in();
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("en.lost.valid", 32'(bus.out_valid), 32'd0);
    chk("en.lost.out", 32'(bus.out), 32'd0);
    chk("en.lost.err", 32'(bus.out_err), 32'd0);
    enable = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("en.no_replay", 32'(bus.out_valid), 32'd0);

    // Async reset between edges, mid-SUM with stale data in the output register.
    beat(8'd1, pk(9,9), pk(0,0), 1'b0);
    @(posedge clk); #1; beat(8'd6, pk(2,2), pk(0,0), 1'b0);
    @(posedge clk); #1; beat(8'd6, pk(2,2), pk(0,0), 1'b0);
    @(posedge clk); #1; idle_in();
    #2;
    reset = 1'b0;
    #1;
    chk("arst.out", 32'(bus.out), 32'd0);
    chk("arst.valid", 32'(bus.out_valid), 32'd0);
    chk("arst.in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    beat(8'd6, pk(1,1), pk(0,0), 1'b1);
    @(posedge clk); #1; idle_in();
    chk_res("arst.sum", pk(1,1), 2'b00, 1'b0);
    @(posedge clk); #1;

    // Random traffic against the reference model.
    for (int i = 0; i < 2; i++) begin
      macc[i] = 0;
      msticky[i] = 1'b0;
    end
    exq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      begin
        int r;
        logic [7:0] c;
        r = $urandom_range(0, 9);
        if (r <= 6) c = 8'(r);
        else if (r <= 8) c = 8'd6;
        else c = 8'($urandom_range(7, 255));
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.cmd       = c;
        bus.in1       = 16'($urandom);
        bus.in2       = 16'($urandom);
        bus.in_last   = ($urandom_range(0, 3) == 0);
        bus.out_ready = ($urandom_range(0, 9) < 7);
      end
      @(negedge clk);
      chk("rnd.in_ready", 32'(bus.in_ready), 32'(enable && (!bus.out_valid || bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (exq.size() == 0) begin
          chk("rnd.unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exq.pop_front();
          chk("rnd.result", 32'({bus.out, bus.out_ovf, bus.out_err}), 32'(e));
        end
      end
      if (bus.in_valid && bus.in_ready)
        model_beat(bus.cmd, bus.in1, bus.in2, bus.in_last);
    end
    @(posedge clk); #1;
    idle_in();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (exq.size() == 0) begin
          chk("drain.unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exq.pop_front();
          chk("drain.result", 32'({bus.out, bus.out_ovf, bus.out_err}), 32'(e));
        end
      end
    end
    chk("drain.queue_empty", 32'(exq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vec_alu.md
VEC_ALU -- requirements
Module: vec_alu

Interface
REQ-001 Parameter NUM_SIZE, default 32, signed element width in bits.
REQ-002 Parameter LANES, default 4, number of parallel elements per beat.
REQ-003 Parameter CMD_SIZE_LOG2, default 3, sets cmd width to 2**CMD_SIZE_LOG2 bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  block enable; low means synchronous flush and idle.
REQ-007 in_valid  input  1  input beat offered.
REQ-008 in_ready  output  1  block accepts the input beat this cycle.
REQ-009 in_last  input  1  marks the final beat of a SUM reduction.
REQ-010 cmd  input  2**CMD_SIZE_LOG2  opcode, sampled with the beat.
REQ-011 in1, in2  input  LANES*NUM_SIZE  packed signed operands; lane i is bits [i*NUM_SIZE +: NUM_SIZE].
REQ-012 out_valid  output  1  result beat offered.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out  output  LANES*NUM_SIZE  packed signed result.
REQ-015 out_ovf  output  LANES  per-lane signed overflow flag.
REQ-016 out_err  output  1  illegal opcode flag.

Function
REQ-017 Handshake: beat accepted when in_valid && in_ready; result transferred when out_valid && out_ready.
REQ-018 in_ready SHALL equal enable && (!out_valid || out_ready).
REQ-019 A result SHALL appear on out_valid exactly 1 cycle after acceptance of its producing beat.
REQ-020 out, out_ovf and out_err SHALL hold stable while out_valid && !out_ready.
REQ-021 Opcodes: 0 NOOP, 1 ADD, 2 SUB, 3 MUL, 4 MIN, 5 MAX, 6 SUM; all other values are illegal.
REQ-022 ADD, SUB and MUL SHALL compute in1 op in2 per lane with two's-complement wrap. MUL SHALL return the low NUM_SIZE bits of the product.
REQ-023 out_ovf[i] SHALL be set when the lane-i true result is outside the signed NUM_SIZE range; MIN and MAX SHALL give out_ovf=0.
REQ-024 NOOP SHALL consume the beat and produce no result.
REQ-025 An illegal opcode SHALL consume the beat and produce one result with out=0, out_ovf=0 and out_err=1.
REQ-026 SUM, non-last beat: acc[i] += in1 lane i, wrapped; in2 is ignored; no result is produced; a per-lane sticky overflow bit is updated.
REQ-027 SUM with in_last=1: produce a result of acc[i]+in1 lane i with the combined sticky overflow, then clear acc and sticky bits.
REQ-028 A SUM with in_last=1 and no prior open accumulation SHALL output in1 unchanged.
REQ-029 Accepting a non-SUM opcode while an accumulation is open SHALL discard acc and sticky bits; that beat is then processed normally.
REQ-030 in_last SHALL be ignored for all opcodes other than SUM.
REQ-031 enable low SHALL clear out_valid, out, out_ovf, out_err, acc and sticky bits at the next edge; in_ready=0 while enable is low.
REQ-032 A result stalled in the output register is lost if enable drops.

Reset
REQ-033 While reset=0: out_valid=0, out=0, out_ovf=0, out_err=0, acc=0, sticky=0, accumulation closed, in_ready=0.
REQ-034 Reset assertion SHALL take effect immediately regardless of clk. Reset mid-accumulation or mid-stall SHALL discard all state.
REQ-035 The first acceptance SHALL occur no earlier than the first rising edge after reset deassertion.

Verification (NUM_SIZE=8, LANES=2)
REQ-036 ADD: in1={100,-5}, in2={27,3} -> 1 cycle later out={127,-2}, out_ovf=00. Then in1={100,0}, in2={28,0} -> out={-128,0}, out_ovf=01 (lane 0 set).
REQ-037 SUM stream: in1={1,2}, {3,4}, {5,6} with in_last on the 3rd beat -> exactly one result, out={9,12}. A following single SUM with in_last=1 and in1={7,7} -> out={7,7}.
REQ-038 Backpressure: out_ready=0 with 3 beats offered -> one result held stable and in_ready=0. out_ready=1 -> results in order, none dropped or duplicated.
REQ-039 Illegal cmd=9 -> out=0, out_err=1. NOOP -> no out_valid pulse.
REQ-040 Async reset asserted mid-SUM (acc={4,4}) between edges -> outputs cleared immediately. Next SUM in_last with in1={1,1} -> out={1,1}.
REQ-041 MUL: in1={16,-3}, in2={8,5} -> out={-128,-15}, out_ovf=01 (lane 0 set). MIN/MAX on {-128,127} and {127,-128} -> {-128,-128} and {127,127}.
